// File: rtl/register_bus_arbiter_pkg.sv
// ============================================================================
// register_bus_arbiter_pkg : shared widths and FSM state type for the arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

package register_bus_arbiter_pkg;

  localparam int DEFAULT_INDEX_WIDTH = 7;
  localparam int DEFAULT_DATA_WIDTH  = 16;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    LOCKED0 = 2'd1,
    LOCKED1 = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/register_bus_arbiter_rr_arbiter2.sv
// ============================================================================
// rr_arbiter2 : two-way round-robin choice; a tie goes to the master not in last
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2
  import register_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (&req) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/register_bus_arbiter.sv
// ============================================================================
// register_bus_arbiter : two-master arbiter onto a single register bus
// Optional bus locking enabled by macro REGISTER_BUS_ARBITER_LOCK_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module register_bus_arbiter
  import register_bus_arbiter_pkg::*;
#(
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m0_req,
  input  logic                   m0_write,
  input  logic                   m0_lock,
  input  logic [INDEX_WIDTH-1:0] m0_index,
  input  logic [DATA_WIDTH-1:0]  m0_write_value,
  output logic                   m0_gnt,
  output logic                   m0_rvalid,
  output logic [DATA_WIDTH-1:0]  m0_read_value,
  input  logic                   m1_req,
  input  logic                   m1_write,
  input  logic                   m1_lock,
  input  logic [INDEX_WIDTH-1:0] m1_index,
  input  logic [DATA_WIDTH-1:0]  m1_write_value,
  output logic                   m1_gnt,
  output logic                   m1_rvalid,
  output logic [DATA_WIDTH-1:0]  m1_read_value,
  output logic [INDEX_WIDTH-1:0] register_index,
  output logic                   register_read,
  output logic                   register_write,
  output logic [DATA_WIDTH-1:0]  register_write_value,
  input  logic [DATA_WIDTH-1:0]  register_read_value
);

  arb_state_t state;
  logic       last;
  logic [1:0] rd_pend;
  logic [1:0] req_eff;
  logic [1:0] grant;

`ifdef REGISTER_BUS_ARBITER_LOCK_EN
  // A locked owner masks the other master out of arbitration entirely.
  always_comb begin
    req_eff = {m1_req && (state != LOCKED0), m0_req && (state != LOCKED1)};
  end
`else
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;

  always_comb begin
    req_eff = {m1_req, m0_req} & {2{state == ARB}};
  end
`endif

  rr_arbiter2 u_rr (
    .req   (req_eff),
    .last  (last),
    .grant (grant)
  );

  assign m0_gnt = grant[0] & ~reset;
  assign m1_gnt = grant[1] & ~reset;

  always_comb begin
    register_index       = '0;
    register_read        = 1'b0;
    register_write       = 1'b0;
    register_write_value = '0;
    if (m0_gnt) begin
      register_index       = m0_index;
      register_read        = ~m0_write;
      register_write       = m0_write;
      register_write_value = m0_write_value;
    end else if (m1_gnt) begin
      register_index       = m1_index;
      register_read        = ~m1_write;
      register_write       = m1_write;
      register_write_value = m1_write_value;
    end
  end

  // Gating with reset drops a read response that lands in a reset cycle.
  assign m0_rvalid     = rd_pend[0] & ~reset;
  assign m1_rvalid     = rd_pend[1] & ~reset;
  assign m0_read_value = m0_rvalid ? register_read_value : '0;
  assign m1_read_value = m1_rvalid ? register_read_value : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB;
      last    <= 1'b1;
      rd_pend <= 2'b00;
    end else begin
      rd_pend <= {m1_gnt & ~m1_write, m0_gnt & ~m0_write};
      if (m0_gnt) begin
        last <= 1'b0;
      end else if (m1_gnt) begin
        last <= 1'b1;
      end
`ifdef REGISTER_BUS_ARBITER_LOCK_EN
      case (state)
        ARB: begin
          if (m0_gnt && m0_lock) begin
            state <= LOCKED0;
          end else if (m1_gnt && m1_lock) begin
            state <= LOCKED1;
          end
        end
        LOCKED0: if (m0_gnt && !m0_lock) state <= ARB;
        LOCKED1: if (m1_gnt && !m1_lock) state <= ARB;
        default: state <= ARB;
      endcase
`else
      state <= ARB;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_register_bus_arbiter.sv
// ============================================================================
// tb_register_bus_arbiter : directed vector table plus randomized traffic
// checked against a transaction-level model of the arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_register_bus_arbiter;

  localparam int IW = 7;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_write, m0_lock, m1_req, m1_write, m1_lock;
  logic [IW-1:0] m0_index, m1_index;
  logic [DW-1:0] m0_write_value, m1_write_value;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_read_value, m1_read_value;
  logic [IW-1:0] register_index;
  logic          register_read, register_write;
  logic [DW-1:0] register_write_value, register_read_value;

  always #5 clk = ~clk;

  register_bus_arbiter #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_lock(m0_lock), .m0_index(m0_index),
    .m0_write_value(m0_write_value), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_read_value(m0_read_value),
    .m1_req(m1_req), .m1_write(m1_write), .m1_lock(m1_lock), .m1_index(m1_index),
    .m1_write_value(m1_write_value), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_read_value(m1_read_value),
    .register_index(register_index), .register_read(register_read),
    .register_write(register_write), .register_write_value(register_write_value),
    .register_read_value(register_read_value)
  );

  typedef struct {
    logic rst;
    logic r0, w0, l0; logic [IW-1:0] i0; logic [DW-1:0] v0;
    logic r1, w1, l1; logic [IW-1:0] i1; logic [DW-1:0] v1;
    logic g0, g1, rv0, rv1;
    logic [IW-1:0] idx; logic rd, wr; logic [DW-1:0] wv;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Transaction-level model: who was served last, who owns a lock, reads in flight.
  int   mdl_last  = 1;
  int   mdl_owner = -1;
  bit   mdl_pend[2];

  function automatic vec_t mk(input int rst,
                              input int r0, input int w0, input int l0, input int i0, input int v0,
                              input int r1, input int w1, input int l1, input int i1, input int v1,
                              input int g0, input int g1, input int rv0, input int rv1,
                              input int idx, input int rd, input int wr, input int wv);
    vec_t v;
    v.rst = rst[0];
    v.r0 = r0[0]; v.w0 = w0[0]; v.l0 = l0[0]; v.i0 = i0[IW-1:0]; v.v0 = v0[DW-1:0];
    v.r1 = r1[0]; v.w1 = w1[0]; v.l1 = l1[0]; v.i1 = i1[IW-1:0]; v.v1 = v1[DW-1:0];
    v.g0 = g0[0]; v.g1 = g1[0]; v.rv0 = rv0[0]; v.rv1 = rv1[0];
    v.idx = idx[IW-1:0]; v.rd = rd[0]; v.wr = wr[0]; v.wv = wv[DW-1:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst;
    m0_req = v.r0; m0_write = v.w0; m0_lock = v.l0; m0_index = v.i0; m0_write_value = v.v0;
    m1_req = v.r1; m1_write = v.w1; m1_lock = v.l1; m1_index = v.i1; m1_write_value = v.v1;
  endtask

  task automatic model_expect(output vec_t e);
    bit q0, q1;
    e = mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0);
    q0 = m0_req && (mdl_owner != 1);
    q1 = m1_req && (mdl_owner != 0);
    if (!reset) begin
      if (q0 && q1) begin
        e.g0 = (mdl_last == 1);
        e.g1 = !e.g0;
      end else begin
        e.g0 = q0;
        e.g1 = q1;
      end
      e.rv0 = mdl_pend[0];
      e.rv1 = mdl_pend[1];
    end
    if (e.g0) begin
      e.idx = m0_index; e.rd = !m0_write; e.wr = m0_write; e.wv = m0_write_value;
    end else if (e.g1) begin
      e.idx = m1_index; e.rd = !m1_write; e.wr = m1_write; e.wv = m1_write_value;
    end
  endtask

  task automatic model_update(input bit g0, input bit g1);
    if (reset) begin
      mdl_last = 1; mdl_owner = -1; mdl_pend[0] = 0; mdl_pend[1] = 0;
    end else begin
      mdl_pend[0] = g0 && !m0_write;
      mdl_pend[1] = g1 && !m1_write;
      if (g0) mdl_last = 0;
      if (g1) mdl_last = 1;
`ifdef REGISTER_BUS_ARBITER_LOCK_EN
      if (mdl_owner < 0) begin
        if (g0 && m0_lock) mdl_owner = 0;
        else if (g1 && m1_lock) mdl_owner = 1;
      end else if (mdl_owner == 0 && g0 && !m0_lock) begin
        mdl_owner = -1;
      end else if (mdl_owner == 1 && g1 && !m1_lock) begin
        mdl_owner = -1;
      end
`endif
    end
  endtask

  // Inputs are already applied; check against the table (use_tbl) or the model, then clock.
  task automatic step(input bit use_tbl, input vec_t v, output bit g0, output bit g1);
    vec_t e, m;
    register_read_value = DW'($urandom);
    #1;
    model_expect(m);
    e = use_tbl ? v : m;
    chk("m0_gnt", 32'(m0_gnt), 32'(e.g0));
    chk("m1_gnt", 32'(m1_gnt), 32'(e.g1));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(e.rv0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(e.rv1));
    chk("m0_read_value", 32'(m0_read_value), e.rv0 ? 32'(register_read_value) : 32'd0);
    chk("m1_read_value", 32'(m1_read_value), e.rv1 ? 32'(register_read_value) : 32'd0);
    chk("register_index", 32'(register_index), 32'(e.idx));
    chk("register_read", 32'(register_read), 32'(e.rd));
    chk("register_write", 32'(register_write), 32'(e.wr));
    chk("register_write_value", 32'(register_write_value), 32'(e.wv));
    g0 = m.g0;
    g1 = m.g1;
    @(posedge clk);
    model_update(m.g0, m.g1);
    @(negedge clk);
  endtask

  initial begin
    vec_t idle, v;
    bit   g0, g1;
    bit   hold0, hold1;

    idle = mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0);
    apply(idle);
    reset = 1'b1;
    register_read_value = '0;
    @(negedge clk);

    // Reset with requests pending, then two reads issued together.
    tbl.push_back(mk(1, 1,0,0,5,0, 1,0,0,6,0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0, 1,0,0,5,0, 1,0,0,6,0, 1,0,0,0, 5,1,0,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 1,0,0,6,0, 0,1,1,0, 6,1,0,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,1, 0,0,0,0));
    // Lone write by m1.
    tbl.push_back(mk(0, 0,0,0,0,0, 1,1,0,'h10,'hBEEF, 0,1,0,0, 'h10,0,1,'hBEEF));
    tbl.push_back(idle);
    // Continuous contention alternates starting with m0.
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0)
        tbl.push_back(mk(0, 1,1,0,1,'h1111, 1,1,0,2,'h2222, 1,0,0,0, 1,0,1,'h1111));
      else
        tbl.push_back(mk(0, 1,1,0,1,'h1111, 1,1,0,2,'h2222, 0,1,0,0, 2,0,1,'h2222));
    end
    tbl.push_back(idle);
    // Reset right after an accepted read suppresses its rvalid and re-arms m0 priority.
    tbl.push_back(mk(0, 1,0,0,3,0, 0,0,0,0,0, 1,0,0,0, 3,1,0,0));
    tbl.push_back(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,0,1,'h1111, 1,1,0,2,'h2222, 1,0,0,0, 1,0,1,'h1111));
    tbl.push_back(idle);
`ifdef REGISTER_BUS_ARBITER_LOCK_EN
    tbl.push_back(mk(0, 1,1,0,1,'h1111, 0,0,0,0,0, 1,0,0,0, 1,0,1,'h1111));
    tbl.push_back(mk(0, 1,1,0,1,'h1111, 1,0,1,9,0, 0,1,0,0, 9,1,0,0));
    tbl.push_back(mk(0, 1,1,0,1,'h1111, 1,1,0,9,'h5A5A, 0,1,0,1, 9,0,1,'h5A5A));
    tbl.push_back(mk(0, 1,1,0,1,'h1111, 0,0,0,0,0, 1,0,0,0, 1,0,1,'h1111));
    tbl.push_back(idle);
`else
    tbl.push_back(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0));
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        tbl.push_back(mk(0, 1,1,1,1,'h1111, 1,1,0,2,'h2222, 1,0,0,0, 1,0,1,'h1111));
      else
        tbl.push_back(mk(0, 1,1,1,1,'h1111, 1,1,0,2,'h2222, 0,1,0,0, 2,0,1,'h2222));
    end
    tbl.push_back(idle);
`endif

    foreach (tbl[i]) begin
      apply(tbl[i]);
      step(1'b1, tbl[i], g0, g1);
    end

    // Random traffic: each master holds its request until served.
    hold0 = 1'b0;
    hold1 = 1'b0;
    v = idle;
    for (int c = 0; c < 400; c++) begin
      v.rst = ($urandom_range(0, 49) == 0);
      if (!hold0) begin
        v.r0 = ($urandom_range(0, 3) != 0);
        v.w0 = 1'($urandom); v.l0 = ($urandom_range(0, 3) == 0);
        v.i0 = IW'($urandom); v.v0 = DW'($urandom);
        hold0 = v.r0;
      end
      if (!hold1) begin
        v.r1 = ($urandom_range(0, 3) != 0);
        v.w1 = 1'($urandom); v.l1 = ($urandom_range(0, 3) == 0);
        v.i1 = IW'($urandom); v.v1 = DW'($urandom);
        hold1 = v.r1;
      end
      apply(v);
      step(1'b0, v, g0, g1);
      if (g0) hold0 = 1'b0;
      if (g1) hold1 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/register_bus_arbiter.md
REGISTER_BUS_ARBITER -- requirements
Module: register_bus_arbiter

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 7, the hardware register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, the register data width.
REQ-003 SHALL have ports: clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports, per master m in {0,1}: m<m>_req in 1, m<m>_write in 1, m<m>_lock in 1, m<m>_index in INDEX_WIDTH, m<m>_write_value in DATA_WIDTH; m<m>_gnt out 1, m<m>_rvalid out 1, m<m>_read_value out DATA_WIDTH.
REQ-006 SHALL drive the register bus: register_index out INDEX_WIDTH, register_read out 1, register_write out 1, register_write_value out DATA_WIDTH, and sample register_read_value in DATA_WIDTH, which is valid one cycle after register_read.

Function
REQ-007 SHALL accept a master's access in the cycle in which that master's req and gnt are both high; gnt SHALL be combinational from req and arbiter state.
REQ-008 SHALL assert at most one gnt per cycle, and gnt SHALL be 0 for a master whose req is low.
REQ-009 SHALL, in the accept cycle, drive the granted master's index and write_value on the bus, with register_write = write and register_read = !write.
REQ-010 SHALL drive register_read = register_write = 0 and register_index = register_write_value = 0 when no access is accepted.
REQ-011 SHALL, in state ARB, when both masters request, grant the master not granted most recently; a sole requester SHALL be granted immediately.
REQ-012 SHALL update the last-granted pointer on every accepted access.
REQ-013 SHALL assert m<m>_rvalid for exactly one cycle, the cycle after an accepted read by m, with m<m>_read_value = register_read_value.
REQ-014 SHALL hold m<m>_read_value at 0 whenever m<m>_rvalid is low, and SHALL produce no rvalid for writes.
REQ-015 SHALL support back-to-back accepts (one per cycle), so a read in cycle t and the next access in cycle t+1 overlap with the rvalid of t.
REQ-016 SHALL require that a master keep req and its access fields stable until granted; the arbiter does not buffer requests.

Reset
REQ-017 SHALL, while reset is high, drive all gnt, rvalid, register_read and register_write to 0 and all value/index outputs to 0.
REQ-018 SHALL, on reset, set the FSM to ARB and the last-granted pointer to master 1, so master 0 wins the first tie.
REQ-019 SHALL, when reset is asserted during a lock or with a read in flight, abandon the lock and suppress the pending rvalid.

Configuration
REQ-020 SHALL implement bus locking only when macro REGISTER_BUS_ARBITER_LOCK_EN is defined.
REQ-021 SHALL, with the macro defined, move from ARB to LOCKED_m when master m is granted an access with m_lock = 1.
REQ-022 SHALL, in LOCKED_m, grant only master m and return to ARB after m's next accepted access with m_lock = 0.
REQ-023 SHALL, without the macro, ignore both lock inputs and remain permanently in ARB.

Structure
REQ-024 SHALL place the FSM state enum (ARB, LOCKED0, LOCKED1) and the default width constants in package register_bus_arbiter_pkg.
REQ-025 SHALL implement the two-way round-robin choice in sub-module rr_arbiter2 (inputs req[1:0] and last; output grant[1:0]).

Verification
REQ-026 SHALL verify: after reset, m0 and m1 both read (index 5 and 6) and hold -> cycle 0: m0_gnt, index 5; cycle 1: m1_gnt, index 6; m0_rvalid in cycle 1, m1_rvalid in cycle 2.
REQ-027 SHALL verify: m1 writes 16'hBEEF to index 7'h10 alone -> register_write = 1 and register_write_value = BEEF in the same cycle, with no rvalid.
REQ-028 SHALL verify: both masters request continuously for 6 cycles -> grants alternate 0,1,0,1,0,1.
REQ-029 SHALL verify, with LOCK_EN: m1 reads with lock, then writes with lock = 0, while m0 requests throughout -> m1 gets both accesses, then m0 is granted in the next cycle.
REQ-030 SHALL verify: reset asserted the cycle after an accepted m0 read -> m0_rvalid stays 0, and the next tie grants m0.
REQ-031 SHALL verify, without LOCK_EN: m0 asserts lock while m1 requests -> strict alternation holds.
